// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_responder
// Description : Word-addressed main-memory model; posted writes, queued
//               in-order pipelined reads with advisory ready and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int WORD_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 16,
    parameter int READ_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter     INIT_FILE     = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memory_addr,
    input  logic                  memory_write_en,
    input  logic [WORD_WIDTH-1:0] memory_write_data,
    input  logic                  memory_read_addr_valid,
    output logic                  memory_read_ready,
    output logic [WORD_WIDTH-1:0] memory_read_data,
    output logic                  memory_read_valid,
    output logic                  overflow_error
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE   = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ZERO  = 0;
    localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_READY_MAX = (c_PTR_W+1)'(FIFO_DEPTH-2);

    logic [WORD_WIDTH-1:0]    r_mem_q  [2**MEM_ADDR_BITS];
    logic [MEM_ADDR_BITS-1:0] r_fifo_q [FIFO_DEPTH];

    logic [c_PTR_W-1:0]    r_wr_ptr_q, r_wr_ptr_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, r_rd_ptr_d;
    logic [c_PTR_W:0]      r_count_q, r_count_d;
    logic                  r_ready_q, r_ready_d;
    logic                  r_overflow_q, r_overflow_d;
    logic [READ_LATENCY-1:0] r_valid_q, r_valid_d;
    logic [WORD_WIDTH-1:0] r_data_q [READ_LATENCY];
    logic [WORD_WIDTH-1:0] r_data_d [READ_LATENCY];

    logic                     w_push;
    logic                     w_pop;
    logic [MEM_ADDR_BITS-1:0] w_index;

    assign w_index = memory_addr[MEM_ADDR_BITS-1:0];

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^memory_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

    // The single array port goes to the write whenever one is presented;
    // a push into an empty queue cannot be popped on the same edge.
    always_comb begin
        w_pop  = (r_count_q != c_CNT_ZERO) && !memory_write_en;
        w_push = memory_read_addr_valid && ((r_count_q != c_FULL) || w_pop);

        r_wr_ptr_d   = r_wr_ptr_q;
        r_rd_ptr_d   = r_rd_ptr_q;
        r_count_d    = r_count_q;
        r_overflow_d = r_overflow_q;

        if (w_push) begin
            r_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            r_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   r_count_d = r_count_q + c_CNT_ONE;
            2'b01:   r_count_d = r_count_q - c_CNT_ONE;
            default: r_count_d = r_count_q;
        endcase
        if (memory_read_addr_valid && !w_push) begin
            r_overflow_d = 1'b1;
        end

        r_ready_d = (r_count_d <= c_READY_MAX);

        r_valid_d    = '0;
        r_valid_d[0] = w_pop;
        r_data_d[0]  = w_pop ? r_mem_q[r_fifo_q[r_rd_ptr_q]] : r_data_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_valid_d[i] = r_valid_q[i-1];
            r_data_d[i]  = r_valid_q[i-1] ? r_data_q[i-1] : r_data_q[i];
        end
    end

    // Storage arrays carry no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (memory_write_en) begin
            r_mem_q[w_index] <= memory_write_data;
        end
        if (w_push) begin
            r_fifo_q[r_wr_ptr_q] <= w_index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_ready_q    <= 1'b1;
            r_overflow_q <= 1'b0;
            r_valid_q    <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q   <= r_wr_ptr_d;
            r_rd_ptr_q   <= r_rd_ptr_d;
            r_count_q    <= r_count_d;
            r_ready_q    <= r_ready_d;
            r_overflow_q <= r_overflow_d;
            r_valid_q    <= r_valid_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data_q[i] <= r_data_d[i];
            end
        end
    end

    assign memory_read_ready = r_ready_q;
    assign overflow_error    = r_overflow_q;
    assign memory_read_valid = r_valid_q[READ_LATENCY-1];
    assign memory_read_data  = r_data_q[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_responder
// Description : Directed self-checking bench for main_memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memory_addr = '0;
    logic        memory_write_en = 1'b0;
    logic [31:0] memory_write_data = '0;
    logic        memory_read_addr_valid = 1'b0;
    logic        memory_read_ready;
    logic [31:0] memory_read_data;
    logic        memory_read_valid;
    logic        overflow_error;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] rx_data[$];
    int          rx_cyc[$];

    main_memory_responder dut (
        .clk                    (clk),
        .rst                    (rst),
        .memory_addr            (memory_addr),
        .memory_write_en        (memory_write_en),
        .memory_write_data      (memory_write_data),
        .memory_read_addr_valid (memory_read_addr_valid),
        .memory_read_ready      (memory_read_ready),
        .memory_read_data       (memory_read_data),
        .memory_read_valid      (memory_read_valid),
        .overflow_error         (overflow_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Returned words are captured at the falling edge together with the
    // index of the rising edge that launched them.
    always @(negedge clk) begin
        if (memory_read_valid) begin
            rx_data.push_back(memory_read_data);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rx(input int n, input int budget);
        for (int t = 0; t < budget && rx_data.size() < n; t++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++; if (memory_read_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", memory_read_valid); end
        n_vec++; if (memory_read_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", memory_read_data); end
        n_vec++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow_error); end
        n_vec++; if (memory_read_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", memory_read_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload;
        for (int i = 0; i < 80; i++) begin
            memory_write_en   = 1'b1;
            memory_addr       = i;
            memory_write_data = 32'h1000 + i;
            @(negedge clk);
        end
        memory_write_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_burst;
        int e0;
        rx_data.delete(); rx_cyc.delete();
        e0 = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            memory_read_addr_valid = 1'b1;
            memory_addr            = 32'h40 + i;
            @(negedge clk);
        end
        memory_read_addr_valid = 1'b0;
        wait_rx(16, 40);
        n_vec++; if (rx_data.size() !== 16) begin n_err++; $display("FAIL burst_count: got %0d expected 16", rx_data.size()); end
        for (int k = 0; k < 16 && k < rx_data.size(); k++) begin
            n_vec++; if (rx_data[k] !== 32'h1040 + k) begin n_err++; $display("FAIL burst_data[%0d]: got %h expected %h", k, rx_data[k], 32'h1040 + k); end
            n_vec++; if (rx_cyc[k] !== e0 + 2 + k) begin n_err++; $display("FAIL burst_cycle[%0d]: got %0d expected %0d", k, rx_cyc[k], e0 + 2 + k); end
        end
        n_vec++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL burst_overflow: got %b expected 0", overflow_error); end
    endtask

    task automatic test_write_read;
        int e0;
        rx_data.delete(); rx_cyc.delete();
        memory_write_en = 1'b1; memory_addr = 32'h123; memory_write_data = 32'hDEADBEEF;
        @(negedge clk);
        memory_write_en = 1'b0; memory_read_addr_valid = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        wait_rx(1, 20);
        n_vec++; if (rx_data.size() !== 1) begin n_err++; $display("FAIL wr_rd_count: got %0d expected 1", rx_data.size()); end
        if (rx_data.size() > 0) begin
            n_vec++; if (rx_data[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_data: got %h expected deadbeef", rx_data[0]); end
            n_vec++; if (rx_cyc[0] !== e0 + 2) begin n_err++; $display("FAIL wr_rd_cycle: got %0d expected %0d", rx_cyc[0], e0 + 2); end
        end
    endtask

    task automatic test_write_stall;
        int e0;
        logic [31:0] exp_d[3];
        exp_d[0] = 32'h1005; exp_d[1] = 32'h000000AA; exp_d[2] = 32'h1007;
        rx_data.delete(); rx_cyc.delete();
        e0 = cyc + 1;
        memory_read_addr_valid = 1'b1; memory_addr = 32'h5;
        @(negedge clk);
        memory_write_en = 1'b1; memory_addr = 32'h6; memory_write_data = 32'hAA;
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        repeat (2) @(negedge clk);
        memory_write_en = 1'b0; memory_read_addr_valid = 1'b1; memory_addr = 32'h7;
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        wait_rx(3, 20);
        n_vec++; if (rx_data.size() !== 3) begin n_err++; $display("FAIL stall_count: got %0d expected 3", rx_data.size()); end
        for (int k = 0; k < 3 && k < rx_data.size(); k++) begin
            n_vec++; if (rx_data[k] !== exp_d[k]) begin n_err++; $display("FAIL stall_data[%0d]: got %h expected %h", k, rx_data[k], exp_d[k]); end
            n_vec++; if (rx_cyc[k] !== e0 + 5 + k) begin n_err++; $display("FAIL stall_cycle[%0d]: got %0d expected %0d", k, rx_cyc[k], e0 + 5 + k); end
        end
    endtask

    task automatic test_ready_overflow;
        logic exp_rdy;
        rx_data.delete(); rx_cyc.delete();
        memory_write_en = 1'b1; memory_addr = 32'h200; memory_write_data = 32'hCAFE0200;
        memory_read_addr_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_rdy = (k + 1 <= 6);
            n_vec++; if (memory_read_ready !== exp_rdy) begin n_err++; $display("FAIL ready_occ%0d: got %b expected %b", k + 1, memory_read_ready, exp_rdy); end
        end
        memory_read_addr_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL ovf_full_no_drop: got %b expected 0", overflow_error); end
        memory_read_addr_valid = 1'b1;
        repeat (2) @(negedge clk);
        memory_read_addr_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (overflow_error !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow_error); end
        memory_write_en = 1'b0;
        wait_rx(8, 30);
        repeat (5) @(negedge clk);
        n_vec++; if (rx_data.size() !== 8) begin n_err++; $display("FAIL ovf_returned: got %0d expected 8", rx_data.size()); end
        for (int k = 0; k < rx_data.size() && k < 8; k++) begin
            n_vec++; if (rx_data[k] !== 32'hCAFE0200) begin n_err++; $display("FAIL ovf_data[%0d]: got %h expected cafe0200", k, rx_data[k]); end
        end
        n_vec++; if (overflow_error !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow_error); end
        n_vec++; if (memory_read_ready !== 1'b1) begin n_err++; $display("FAIL ready_drained: got %b expected 1", memory_read_ready); end
    endtask

    task automatic test_reset_mid_burst;
        for (int i = 0; i < 4; i++) begin
            memory_read_addr_valid = 1'b1; memory_addr = 32'h40 + i;
            @(negedge clk);
        end
        memory_read_addr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_data.delete(); rx_cyc.delete();
        n_vec++; if (memory_read_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", memory_read_valid); end
        n_vec++; if (memory_read_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", memory_read_ready); end
        n_vec++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow: got %b expected 0", overflow_error); end
        repeat (8) @(negedge clk);
        n_vec++; if (rx_data.size() !== 0) begin n_err++; $display("FAIL rstmid_stale_pulses: got %0d expected 0", rx_data.size()); end
        rx_data.delete(); rx_cyc.delete();
        memory_read_addr_valid = 1'b1; memory_addr = 32'h40;
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        wait_rx(1, 20);
        n_vec++; if (rx_data.size() !== 1 || rx_data[0] !== 32'h1040) begin
            n_err++; $display("FAIL rstmid_preserved: got %h (count %0d) expected 00001040", (rx_data.size() > 0) ? rx_data[0] : 32'hx, rx_data.size());
        end
    endtask

    task automatic test_alias;
        rx_data.delete(); rx_cyc.delete();
        memory_read_addr_valid = 1'b1; memory_addr = 32'h0001_0005;
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        wait_rx(1, 20);
        n_vec++; if (rx_data.size() !== 1 || rx_data[0] !== 32'h1005) begin
            n_err++; $display("FAIL alias_data: got %h (count %0d) expected 00001005", (rx_data.size() > 0) ? rx_data[0] : 32'hx, rx_data.size());
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_burst();
        test_write_read();
        test_write_stall();
        test_ready_overflow();
        test_reset_mid_burst();
        test_alias();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
